// File: rtl/conv_axi512_to_axi1024.sv
// Packs pairs of IN_W-bit stream beats into one 2*IN_W-bit beat; a packet's odd last beat is zero-padded.
// Optional keep-violation flag enabled by defining CONV_UP_KEEP_CHECK_EN.
module conv_axi512_to_axi1024 #(
  parameter int IN_W = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  input  logic [IN_W/8-1:0]     in_keep,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [2*IN_W-1:0]     out_data,
  output logic [IN_W/4-1:0]     out_keep,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  err_keep
);

  localparam int KW = IN_W / 8;

  typedef enum logic [1:0] {IDLE, HALF, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [IN_W-1:0]       low_data_q, low_data_d;
  logic [KW-1:0]         low_keep_q, low_keep_d;
  logic [2*IN_W-1:0]     out_data_q, out_data_d;
  logic [2*KW-1:0]       out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_free;
  logic                  ready_state;
  logic                  in_fire;

  // Ready is a function of state and output occupancy only, never of the input beat.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    case (state_q)
      IDLE:    ready_state = 1'b1;
      HALF:    ready_state = out_free;
      default: ready_state = 1'b0;
    endcase
  end

  assign in_ready = rst_n && ready_state;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    low_data_d  = low_data_q;
    low_keep_d  = low_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          low_data_d = in_data;
          low_keep_d = in_keep;
          state_d    = in_last ? FLUSH : HALF;
        end
      end
      HALF: begin
        if (in_fire) begin
          out_data_d  = {in_data, low_data_q};
          out_keep_d  = {in_keep, low_keep_q};
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        // A last beat without a partner goes out alone with the upper half zeroed.
        if (out_free) begin
          out_data_d  = {{IN_W{1'b0}}, low_data_q};
          out_keep_d  = {{KW{1'b0}}, low_keep_q};
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      low_data_q  <= '0;
      low_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_data_q  <= low_data_d;
      low_keep_q  <= low_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef CONV_UP_KEEP_CHECK_EN
  logic          err_keep_q, err_keep_d;
  logic [KW-1:0] keep_inc;
  logic          keep_bad;

  // Contiguous-from-bit-0 keep satisfies keep & (keep + 1) == 0.
  always_comb begin
    keep_inc   = in_keep + {{(KW-1){1'b0}}, 1'b1};
    keep_bad   = in_last ? |(in_keep & keep_inc) : !(&in_keep);
    err_keep_d = err_keep_q || (in_fire && keep_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_keep_q <= 1'b0;
    else        err_keep_q <= err_keep_d;
  end

  assign err_keep = err_keep_q;
`else
  assign err_keep = 1'b0;
`endif

endmodule

// File: tb/tb_conv_axi512_to_axi1024.sv
// Randomized bench for conv_axi512_to_axi1024 with a pairing reference model over accepted beats.
module tb_conv_axi512_to_axi1024;

  localparam int IN_W = 512;
  localparam int KW   = IN_W / 8;
`ifdef CONV_UP_KEEP_CHECK_EN
  localparam logic KC = 1'b1;
`else
  localparam logic KC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IN_W-1:0]   in_data;
  logic [KW-1:0]     in_keep;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [2*IN_W-1:0] out_data;
  logic [2*KW-1:0]   out_keep;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              err_keep;

  conv_axi512_to_axi1024 #(.IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .err_keep(err_keep)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IN_W-1:0] d; logic [KW-1:0] k; logic l; int cyc; } ibeat_t;
  typedef struct packed { logic [2*IN_W-1:0] d; logic [2*KW-1:0] k; logic l; int cyc; } obeat_t;
  typedef struct packed { logic ir; logic ov; logic ordy; logic acc; int cyc; } trace_t;

  ibeat_t acc_q[$];
  obeat_t obs_q[$];
  trace_t tr_q[$];
  obeat_t exp_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   cycle_cnt = 0;
  int   rdy_mode = 0;
  int   win_base = 0;
  logic last_acc = 1'b0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Passive recorder of handshakes; all judging happens in the test tasks.
  always @(negedge clk) begin
    if (rst_n) begin
      tr_q.push_back({in_ready, out_valid, out_ready, in_valid && in_ready, cycle_cnt});
      if (in_valid && in_ready) acc_q.push_back({in_data, in_keep, in_last, cycle_cnt});
      if (out_valid && out_ready) obs_q.push_back({out_data, out_keep, out_last, cycle_cnt});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    int rel;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    rel = cycle_cnt - win_base;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = !(rel >= 3 && rel <= 6);
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1; n = 0;
    do begin tick(); n++; end while (!last_acc && n < 200);
    if (!last_acc) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [IN_W-1:0] rand_data();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [KW-1:0] rand_last_keep();
    int n;
    logic [KW-1:0] k;
    n = $urandom_range(1, KW);
    k = '1;
    return k >> (KW - n);
  endfunction

  // Reference: consecutive beats of a packet pair up low-then-high; an unpaired last beat goes alone.
  task automatic build_exp(input int abase);
    ibeat_t a, b;
    obeat_t o;
    logic have;
    have = 1'b0;
    a = '0;
    exp_q.delete();
    for (int i = abase; i < acc_q.size(); i++) begin
      b = acc_q[i];
      if (have) begin
        o.d = {b.d, a.d}; o.k = {b.k, a.k}; o.l = b.l; o.cyc = b.cyc + 1;
        exp_q.push_back(o);
        have = 1'b0;
      end else if (b.l) begin
        o.d = {{IN_W{1'b0}}, b.d}; o.k = {{KW{1'b0}}, b.k}; o.l = 1'b1; o.cyc = b.cyc + 2;
        exp_q.push_back(o);
      end else begin
        a = b;
        have = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got lo=%h want 0", out_data[63:0]); end
    vectors++; if (out_keep !== '0) begin miscompares++; $display("FAIL rst_out_keep: got %h want 0", out_keep); end
    vectors++; if (err_keep !== 1'b0) begin miscompares++; $display("FAIL rst_err_keep: got %b want 0", err_keep); end
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pair();
    logic [IN_W-1:0] d0, d1;
    logic [2*IN_W-1:0] ed;
    obeat_t o;
    int abase, obase;
    abase = acc_q.size(); obase = obs_q.size();
    out_ready = 1'b1; rdy_mode = 0;
    d0 = rand_data(); d1 = rand_data();
    send_beat(d0, '1, 1'b0);
    send_beat(d1, '1, 1'b1);
    idle(4);
    build_exp(abase);
    ed = {d1, d0};
    vectors++;
    if (obs_q.size() - obase !== 1) begin
      miscompares++; $display("FAIL pair_count: got %0d beats want 1", obs_q.size() - obase);
    end else begin
      o = obs_q[obase];
      vectors++; if (o.d !== ed) begin miscompares++; $display("FAIL pair_data: got lo=%h hi=%h want lo=%h hi=%h", o.d[63:0], o.d[IN_W +: 64], ed[63:0], ed[IN_W +: 64]); end
      vectors++; if (o.k !== {2*KW{1'b1}}) begin miscompares++; $display("FAIL pair_keep: got %h want all ones", o.k); end
      vectors++; if (o.l !== 1'b1) begin miscompares++; $display("FAIL pair_last: got %b want 1", o.l); end
      vectors++; if (o.cyc !== exp_q[0].cyc) begin miscompares++; $display("FAIL pair_latency: got cycle %0d want %0d", o.cyc, exp_q[0].cyc); end
    end
  endtask

  task automatic test_odd_packet();
    logic [IN_W-1:0] d0, d1, d2;
    logic [2*IN_W-1:0] ed;
    obeat_t o;
    int abase, obase;
    abase = acc_q.size(); obase = obs_q.size();
    out_ready = 1'b1; rdy_mode = 0;
    d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
    send_beat(d0, '1, 1'b0);
    send_beat(d1, '1, 1'b0);
    send_beat(d2, 64'h0000_0000_0000_00FF, 1'b1);
    idle(5);
    build_exp(abase);
    vectors++;
    if (obs_q.size() - obase !== 2) begin
      miscompares++; $display("FAIL odd_count: got %0d beats want 2", obs_q.size() - obase);
    end else begin
      o = obs_q[obase]; ed = {d1, d0};
      vectors++; if (o.d !== ed || o.l !== 1'b0) begin miscompares++; $display("FAIL odd_first: got lo=%h l=%b want lo=%h l=0", o.d[63:0], o.l, ed[63:0]); end
      o = obs_q[obase + 1];
      vectors++; if (o.k !== {64'h0, 64'hFF}) begin miscompares++; $display("FAIL odd_keep: got %h want %h", o.k, {64'h0, 64'hFF}); end
      vectors++; if (o.d[2*IN_W-1:IN_W] !== '0) begin miscompares++; $display("FAIL odd_upper: got %h want 0", o.d[IN_W +: 64]); end
      vectors++; if (o.d[IN_W-1:0] !== d2) begin miscompares++; $display("FAIL odd_lower: got %h want %h", o.d[63:0], d2[63:0]); end
      vectors++; if (o.l !== 1'b1) begin miscompares++; $display("FAIL odd_last: got %b want 1", o.l); end
      vectors++; if (o.cyc !== exp_q[1].cyc) begin miscompares++; $display("FAIL odd_latency: got cycle %0d want %0d", o.cyc, exp_q[1].cyc); end
    end
  endtask

  task automatic test_throughput();
    int abase, obase, tbase, nacc, n;
    abase = acc_q.size(); obase = obs_q.size(); tbase = tr_q.size();
    out_ready = 1'b1; rdy_mode = 0;
    for (int i = 0; i < 16; i++) send_beat(rand_data(), '1, i == 15);
    idle(4);
    build_exp(abase);
    nacc = 0;
    for (int i = tbase; i < tr_q.size() && nacc < 16; i++) begin
      vectors++;
      if (tr_q[i].ir !== 1'b1) begin miscompares++; $display("FAIL tput_ready: got 0 at cycle %0d want 1", tr_q[i].cyc); end
      if (tr_q[i].acc) nacc++;
    end
    n = obs_q.size() - obase;
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL tput_count: got %0d beats want 8", n); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[obase+i].d !== exp_q[i].d || obs_q[obase+i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL tput_beat%0d: got lo=%h l=%b want lo=%h l=%b", i, obs_q[obase+i].d[63:0], obs_q[obase+i].l, exp_q[i].d[63:0], exp_q[i].l);
      end
      if (i > 0) begin
        vectors++;
        if (obs_q[obase+i].cyc - obs_q[obase+i-1].cyc !== 2) begin
          miscompares++; $display("FAIL tput_spacing%0d: got %0d cycles want 2", i, obs_q[obase+i].cyc - obs_q[obase+i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int abase, obase, tbase, nacc, n, stalls;
    logic exp_ir;
    abase = acc_q.size(); obase = obs_q.size(); tbase = tr_q.size();
    win_base = cycle_cnt; out_ready = 1'b1; rdy_mode = 2;
    for (int i = 0; i < 8; i++) send_beat(rand_data(), '1, i == 7);
    rdy_mode = 0; out_ready = 1'b1;
    idle(6);
    build_exp(abase);
    nacc = 0; stalls = 0;
    for (int i = tbase; i < tr_q.size() && nacc < 8; i++) begin
      exp_ir = (nacc % 2 == 1) ? (!tr_q[i].ov || tr_q[i].ordy) : 1'b1;
      if (nacc % 2 == 1 && tr_q[i].ov && !tr_q[i].ordy) stalls++;
      vectors++;
      if (tr_q[i].ir !== exp_ir) begin miscompares++; $display("FAIL bp_ready: got %b at cycle %0d want %b", tr_q[i].ir, tr_q[i].cyc, exp_ir); end
      if (tr_q[i].acc) nacc++;
    end
    vectors++;
    if (stalls < 1) begin miscompares++; $display("FAIL bp_stall: got %0d stalled half cycles want >=1", stalls); end
    n = obs_q.size() - obase;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL bp_count: got %0d beats want 4", n); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[obase+i].d !== exp_q[i].d || obs_q[obase+i].k !== exp_q[i].k || obs_q[obase+i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL bp_beat%0d: got lo=%h hi=%h l=%b want lo=%h hi=%h l=%b", i, obs_q[obase+i].d[63:0], obs_q[obase+i].d[IN_W +: 64], obs_q[obase+i].l, exp_q[i].d[63:0], exp_q[i].d[IN_W +: 64], exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [IN_W-1:0] e0, e1;
    logic [2*IN_W-1:0] ed;
    int abase, obase;
    out_ready = 1'b0; rdy_mode = 0;
    send_beat(rand_data(), '1, 1'b0);
    send_beat(rand_data(), '1, 1'b1);
    send_beat(rand_data(), '1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL midrst_data: got lo=%h want 0", out_data[63:0]); end
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    abase = acc_q.size(); obase = obs_q.size();
    e0 = rand_data(); e1 = rand_data();
    send_beat(e0, '1, 1'b0);
    send_beat(e1, '1, 1'b1);
    idle(5);
    ed = {e1, e0};
    vectors++;
    if (obs_q.size() - obase !== 1) begin
      miscompares++; $display("FAIL midrst_count: got %0d beats want 1", obs_q.size() - obase);
    end else begin
      vectors++;
      if (obs_q[obase].d !== ed || obs_q[obase].l !== 1'b1) begin
        miscompares++; $display("FAIL midrst_beat: got lo=%h hi=%h l=%b want lo=%h hi=%h l=1", obs_q[obase].d[63:0], obs_q[obase].d[IN_W +: 64], obs_q[obase].l, ed[63:0], ed[IN_W +: 64]);
      end
    end
  endtask

  task automatic test_keep_check();
    logic [IN_W-1:0] d0, d1;
    logic [2*IN_W-1:0] ed;
    logic [2*KW-1:0] ek;
    int abase, obase;
    out_ready = 1'b1; rdy_mode = 0;
    rst_n = 1'b0;
    #1;
    vectors++; if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_rst0: got %b want 0", err_keep); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    abase = acc_q.size(); obase = obs_q.size();
    d0 = rand_data(); d1 = rand_data();
    send_beat(d0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    vectors++; if (err_keep !== KC) begin miscompares++; $display("FAIL keep_nonlast: got %b want %b", err_keep, KC); end
    send_beat(d1, '1, 1'b1);
    idle(3);
    vectors++; if (err_keep !== KC) begin miscompares++; $display("FAIL keep_sticky: got %b want %b", err_keep, KC); end
    ed = {d1, d0}; ek = {{KW{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE};
    vectors++;
    if (obs_q.size() - obase !== 1) begin
      miscompares++; $display("FAIL keep_count: got %0d beats want 1", obs_q.size() - obase);
    end else begin
      vectors++;
      if (obs_q[obase].d !== ed || obs_q[obase].k !== ek) begin
        miscompares++; $display("FAIL keep_datapath: got lo=%h k=%h want lo=%h k=%h", obs_q[obase].d[63:0], obs_q[obase].k, ed[63:0], ek);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_cleared: got %b want 0", err_keep); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(rand_data(), 64'h0000_0000_0000_000F, 1'b1);
    idle(3);
    vectors++; if (err_keep !== 1'b0) begin miscompares++; $display("FAIL keep_contig_ok: got %b want 0", err_keep); end
    send_beat(rand_data(), 64'h0000_0000_0000_00F0, 1'b1);
    vectors++; if (err_keep !== KC) begin miscompares++; $display("FAIL keep_noncontig: got %b want %b", err_keep, KC); end
    idle(4);
  endtask

  task automatic test_random();
    int abase, obase, n, len;
    abase = acc_q.size(); obase = obs_q.size();
    rdy_mode = 1; out_ready = 1'($urandom_range(0, 1));
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        if (b == len - 1) send_beat(rand_data(), rand_last_keep(), 1'b1);
        else send_beat(rand_data(), '1, 1'b0);
        idle($urandom_range(0, 2));
      end
    end
    rdy_mode = 0; out_ready = 1'b1;
    idle(10);
    build_exp(abase);
    n = obs_q.size() - obase;
    vectors++;
    if (n !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d beats want %0d", n, exp_q.size()); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[obase+i].d !== exp_q[i].d || obs_q[obase+i].k !== exp_q[i].k || obs_q[obase+i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL rand_beat%0d: got lo=%h hi=%h k=%h l=%b want lo=%h hi=%h k=%h l=%b", i, obs_q[obase+i].d[63:0], obs_q[obase+i].d[IN_W +: 64], obs_q[obase+i].k, obs_q[obase+i].l, exp_q[i].d[63:0], exp_q[i].d[IN_W +: 64], exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_pair();
    test_odd_packet();
    test_throughput();
    test_backpressure();
    test_reset_mid();
    test_keep_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
